alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Operand/result staging unit that sits directly in front of, and behind, the combinational 8-bit ALU. It accepts operands from the shared datapath bus one beat at a time, holds operand A in a Y register, presents A/B/opcode to the ALU for exactly one execute cycle, and latches the result into a Z register. Z is held, with status flags, until the downstream consumer takes it. Unary opcodes need only one bus beat; all others need two.

## Interface
Parameters:
- WIDTH, 8, data width of bus, operands, ALU result and Z.
- OPW, 4, opcode width.
- CNTW, 16, width of completed-operation counter.

Ports:
- clock  in  1  single clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- bus_data  in  WIDTH  operand beat from datapath bus.
- bus_op  in  OPW  opcode; sampled only on the A beat.
- bus_valid  in  1  bus beat present.
- bus_ready  out  1  stage can accept a beat.
- alu_a  out  WIDTH  operand A to ALU (Y register).
- alu_b  out  WIDTH  operand B to ALU (B register).
- alu_op  out  OPW  opcode to ALU (opcode register).
- alu_result  in  WIDTH  combinational ALU result.
- z_out  out  WIDTH  latched result.
- z_valid  out  1  z_out and flags valid.
- z_ready  in  1  consumer takes Z.
- z_zero  out  1  z_out == 0.
- z_neg  out  1  z_out[WIDTH-1].
- z_divzero  out  1  DIV (7) with B == 0.
- z_illegal  out  1  opcode not in the supported set.
- busy  out  1  state != IDLE.
- op_count  out  CNTW  number of results delivered; wraps.

## Operation
- Supported opcodes: 0 OR, 1 AND, 2 NOT, 3 ADD, 4 SUB, 5 NEG, 7 DIV, 8 SHL, 9 SHR, 11 ROL, 12 ROR. Unary: 2 and 5. All others are illegal.
- States: IDLE, WAIT_B, EXEC, DONE.
- IDLE: bus_ready=1. On handshake, Y<=bus_data and opcode reg<=bus_op.
  - If the opcode is unary, or illegal, B<=0 and go to EXEC.
  - Otherwise go to WAIT_B.
- WAIT_B: bus_ready=1. On handshake, B<=bus_data and go to EXEC.
- EXEC: bus_ready=0. The ALU inputs are stable for the whole cycle. At the end of the cycle, Z and the flags are captured and the state moves to DONE.
  - Normal case: Z<=alu_result.
  - Illegal opcode: Z<=0, z_illegal=1.
  - DIV with B==0: Z<={WIDTH{1'b1}}, z_divzero=1, and alu_result is ignored.
  - z_zero and z_neg are computed from the captured Z value.
- DONE: z_valid=1. On z_ready, go to IDLE and increment op_count (modulo 2^CNTW). With z_ready low, Z and all flags hold indefinitely.
- Shift/rotate amounts are B unmodified; range handling is the ALU's responsibility.
- A new operation cannot overlap a pending Z. bus_ready=0 in EXEC and DONE.

## Timing
- Reset values: state IDLE; Y, B, opcode reg, z_out, op_count = 0; z_valid, z_zero, z_neg, z_divzero, z_illegal, busy = 0.
- bus_ready is 1 in IDLE and WAIT_B.
- Binary op: A accepted at edge k, B at edge k+1 at the earliest, EXEC during cycle k+1..k+2, z_valid high from edge k+3. From B acceptance to z_valid is 2 edges.
- Unary op: A accepted at edge k, z_valid high from edge k+2.
- bus_valid may drop in WAIT_B. The stage waits indefinitely; there is no timeout.
- z_valid falls on the edge after the z_ready handshake. IDLE is re-entered on that same edge, and the next A can be accepted on the following edge.
- clear asserted in any state: on the next edge, all registers return to reset values. Any partial operation is discarded and op_count is not incremented.
- clear has priority over a simultaneous bus or z handshake.
- op_count wraps from 2^CNTW-1 to 0.

## Structure
- Shared package/include (alu_defs): opcode localparams (OP_OR … OP_ROR), the unary-opcode and legal-opcode predicates, and the state encoding.
- One natural sub-module: alu_op_decode. It is combinational (opcode → is_unary, is_legal, is_div) and is reused by the future control unit.
- The ALU itself is instantiated outside this block, in the datapath top.

## Test plan
- ADD: A=20/op=3, then B=5 → alu_a=20, alu_b=5 in EXEC; z_out=25, z_valid 2 edges after B, z_zero=0, op_count=1.
- NOT unary: A=20/op=2 → no B beat (bus_ready=0 after one beat); z_out=235, z_neg=1, z_valid at k+2.
- Backpressure: SUB 20-5 with z_ready held low 4 cycles → z_out=15 and flags stable, bus_ready=0 throughout; op_count increments only on the handshake.
- DIV by zero: A=20/op=7, B=0 → z_out=8'hFF, z_divzero=1. A following DIV 20/5 → z_out=4, z_divzero=0.
- Illegal op 13: A=9/op=13 → single beat, z_out=0, z_illegal=1, z_zero=1. Same sequence with op 6 gives the same result.
- clear in WAIT_B (A=178/op=8 accepted) → next edge IDLE, all outputs at reset values. Then ROL 178 by 2 completes normally with z_out=8'b11001010.

Source files
------------

// File: rtl/alu_defs.sv
// Shared opcode constants, opcode predicates and the staging FSM state encoding
// for the ALU operand/result stage and the future control unit.
package alu_defs;

  localparam int unsigned OP_OR  = 0;
  localparam int unsigned OP_AND = 1;
  localparam int unsigned OP_NOT = 2;
  localparam int unsigned OP_ADD = 3;
  localparam int unsigned OP_SUB = 4;
  localparam int unsigned OP_NEG = 5;
  localparam int unsigned OP_DIV = 7;
  localparam int unsigned OP_SHL = 8;
  localparam int unsigned OP_SHR = 9;
  localparam int unsigned OP_ROL = 11;
  localparam int unsigned OP_ROR = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWaitB = 2'd1,
    StExec  = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic op_is_unary(input int unsigned op);
    return (op == OP_NOT) || (op == OP_NEG);
  endfunction

  function automatic logic op_is_legal(input int unsigned op);
    case (op)
      OP_OR, OP_AND, OP_NOT, OP_ADD, OP_SUB, OP_NEG,
      OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: unary / legal / divide.
module alu_op_decode
  import alu_defs::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] op,
  output logic           is_unary,
  output logic           is_legal,
  output logic           is_div
);

  always_comb begin
    is_unary = op_is_unary(32'(op));
    is_legal = op_is_legal(32'(op));
    is_div   = (op == OPW'(OP_DIV));
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand/result staging around the combinational ALU: collects A (and B for binary
// ops), drives the ALU for one execute cycle, and holds Z with flags until consumed.
module alu_operand_stage
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] bus_data,
  input  logic [OPW-1:0]   bus_op,
  input  logic             bus_valid,
  output logic             bus_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] z_out,
  output logic             z_valid,
  input  logic             z_ready,
  output logic             z_zero,
  output logic             z_neg,
  output logic             z_divzero,
  output logic             z_illegal,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  state_e           state;
  logic [WIDTH-1:0] y_reg, b_reg, z_reg;
  logic [OPW-1:0]   op_reg;
  logic             z_valid_reg, zero_reg, neg_reg, divzero_reg, illegal_reg;
  logic [CNTW-1:0]  count_reg;

  logic             in_unary, in_legal, in_div;
  logic             ex_unary, ex_legal, ex_div;
  logic [WIDTH-1:0] z_next;
  logic             divzero_next, illegal_next;

  // Incoming opcode decides the beat count; the latched opcode decides the result path.
  alu_op_decode #(.OPW(OPW)) u_decode_in (
    .op       (bus_op),
    .is_unary (in_unary),
    .is_legal (in_legal),
    .is_div   (in_div)
  );

  alu_op_decode #(.OPW(OPW)) u_decode_ex (
    .op       (op_reg),
    .is_unary (ex_unary),
    .is_legal (ex_legal),
    .is_div   (ex_div)
  );

  always_comb begin
    z_next       = alu_result;
    divzero_next = 1'b0;
    illegal_next = 1'b0;
    if (!ex_legal) begin
      z_next       = '0;
      illegal_next = 1'b1;
    end else if (ex_div && (b_reg == '0)) begin
      z_next       = '1;
      divzero_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= StIdle;
      y_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      z_reg       <= '0;
      z_valid_reg <= 1'b0;
      zero_reg    <= 1'b0;
      neg_reg     <= 1'b0;
      divzero_reg <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (bus_valid) begin
            y_reg  <= bus_data;
            op_reg <= bus_op;
            if (in_unary || !in_legal) begin
              b_reg <= '0;
              state <= StExec;
            end else begin
              state <= StWaitB;
            end
          end
        end
        StWaitB: begin
          if (bus_valid) begin
            b_reg <= bus_data;
            state <= StExec;
          end
        end
        StExec: begin
          z_reg       <= z_next;
          zero_reg    <= (z_next == '0);
          neg_reg     <= z_next[WIDTH-1];
          divzero_reg <= divzero_next;
          illegal_reg <= illegal_next;
          state       <= StDone;
        end
        StDone: begin
          // z_valid is a registered output, so it rises one edge after Z is captured.
          if (z_valid_reg && z_ready) begin
            z_valid_reg <= 1'b0;
            count_reg   <= count_reg + CNTW'(1);
            state       <= StIdle;
          end else begin
            z_valid_reg <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus_ready = (state == StIdle) || (state == StWaitB);
  assign busy      = (state != StIdle);
  assign alu_a     = y_reg;
  assign alu_b     = b_reg;
  assign alu_op    = op_reg;
  assign z_out     = z_reg;
  assign z_valid   = z_valid_reg;
  assign z_zero    = zero_reg;
  assign z_neg     = neg_reg;
  assign z_divzero = divzero_reg;
  assign z_illegal = illegal_reg;
  assign op_count  = count_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage with a behavioural ALU in the loop.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [7:0] z;
    logic       zero;
    logic       neg;
    logic       dz;
    logic       ill;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  bus_data = '0;
  logic [3:0]  bus_op = '0;
  logic        bus_valid = 1'b0;
  logic        bus_ready;
  logic [7:0]  alu_a, alu_b, alu_result, z_out;
  logic [3:0]  alu_op;
  logic        z_valid, z_zero, z_neg, z_divzero, z_illegal, busy;
  logic        z_ready = 1'b0;
  logic [15:0] op_count;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_count = 0;
  exp_t sb[$];

  alu_operand_stage dut (
    .clock      (clock),
    .clear      (clear),
    .bus_data   (bus_data),
    .bus_op     (bus_op),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .z_out      (z_out),
    .z_valid    (z_valid),
    .z_ready    (z_ready),
    .z_zero     (z_zero),
    .z_neg      (z_neg),
    .z_divzero  (z_divzero),
    .z_illegal  (z_illegal),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural ALU; illegal ops and DIV by zero return junk the stage must override.
  logic [15:0] rot;
  always_comb begin
    rot = '0;
    case (alu_op)
      4'd0:    alu_result = alu_a | alu_b;
      4'd1:    alu_result = alu_a & alu_b;
      4'd2:    alu_result = ~alu_a;
      4'd3:    alu_result = alu_a + alu_b;
      4'd4:    alu_result = alu_a - alu_b;
      4'd5:    alu_result = 8'd0 - alu_a;
      4'd7:    alu_result = (alu_b == 8'd0) ? 8'h5A : alu_a / alu_b;
      4'd8:    alu_result = alu_a << alu_b;
      4'd9:    alu_result = alu_a >> alu_b;
      4'd11: begin
        rot        = {alu_a, alu_a} << alu_b[2:0];
        alu_result = rot[15:8];
      end
      4'd12: begin
        rot        = {alu_a, alu_a} >> alu_b[2:0];
        alu_result = rot[7:0];
      end
      default: alu_result = 8'h5A;
    endcase
  end

  task automatic beat(input logic [7:0] d, input logic [3:0] op, output int edge_no);
    int w = 0;
    @(negedge clock);
    bus_valid = 1'b1;
    bus_data  = d;
    bus_op    = op;
    while (!bus_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (!bus_ready) begin
      errors++;
      $display("FAIL beat_accept: bus_ready=%0b required 1 within 20 cycles", bus_ready);
      bus_valid = 1'b0;
      edge_no   = cyc;
      return;
    end
    @(posedge clock);
    #1;
    bus_valid = 1'b0;
    edge_no   = cyc;
  endtask

  task automatic collect(input int start, input int lat, input string name);
    int   w = 0;
    exp_t e, got;
    @(negedge clock);
    while (!z_valid && w < 20) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (!z_valid || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_valid: z_valid=%0b queued=%0d required z_valid=1 with a queued result",
               name, z_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (cyc - start != lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, cyc - start, lat);
    end
    e   = sb.pop_front();
    got = {z_out, z_zero, z_neg, z_divzero, z_illegal};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s_result: z/zero/neg/dz/ill=%0d/%0b/%0b/%0b/%0b required %0d/%0b/%0b/%0b/%0b",
               name, got.z, got.zero, got.neg, got.dz, got.ill,
               e.z, e.zero, e.neg, e.dz, e.ill);
    end
  endtask

  task automatic release_z(input string name);
    z_ready = 1'b1;
    @(posedge clock);
    #1;
    z_ready = 1'b0;
    exp_count++;
    checks++;
    if (z_valid !== 1'b0 || busy !== 1'b0 || bus_ready !== 1'b1 || op_count !== 16'(exp_count))
    begin
      errors++;
      $display("FAIL %s_release: z_valid=%0b busy=%0b bus_ready=%0b op_count=%0d required 0/0/1/%0d",
               name, z_valid, busy, bus_ready, op_count, exp_count);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    exp_count = 0;
    checks++;
    if ({bus_ready, busy, z_valid, z_zero, z_neg, z_divzero, z_illegal} !== 7'b1000000 ||
        alu_a !== 8'd0 || alu_b !== 8'd0 || alu_op !== 4'd0 || z_out !== 8'd0 ||
        op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rdy/busy/zv/flags=%b a=%0d b=%0d op=%0d z=%0d cnt=%0d required 1000000 and zeros",
               {bus_ready, busy, z_valid, z_zero, z_neg, z_divzero, z_illegal},
               alu_a, alu_b, alu_op, z_out, op_count);
    end
  endtask

  task automatic test_add();
    int ka, kb;
    beat(8'd20, 4'd3, ka);
    checks++;
    if (bus_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_wait_b: bus_ready=%0b busy=%0b required 1/1", bus_ready, busy);
    end
    beat(8'd5, 4'd0, kb);
    sb.push_back('{z: 8'd25, zero: 1'b0, neg: 1'b0, dz: 1'b0, ill: 1'b0});
    checks++;
    if (alu_a !== 8'd20 || alu_b !== 8'd5 || alu_op !== 4'd3 || bus_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_exec: a=%0d b=%0d op=%0d rdy=%0b required 20/5/3/0",
               alu_a, alu_b, alu_op, bus_ready);
    end
    collect(kb, 2, "add");
    release_z("add");
  endtask

  task automatic test_not_unary();
    int ka;
    beat(8'd20, 4'd2, ka);
    sb.push_back('{z: 8'd235, zero: 1'b0, neg: 1'b1, dz: 1'b0, ill: 1'b0});
    checks++;
    if (bus_ready !== 1'b0 || alu_b !== 8'd0) begin
      errors++;
      $display("FAIL not_single_beat: bus_ready=%0b alu_b=%0d required 0/0", bus_ready, alu_b);
    end
    collect(ka, 2, "not");
    release_z("not");
  endtask

  task automatic test_backpressure();
    int ka, kb;
    beat(8'd20, 4'd4, ka);
    beat(8'd5, 4'd0, kb);
    sb.push_back('{z: 8'd15, zero: 1'b0, neg: 1'b0, dz: 1'b0, ill: 1'b0});
    collect(kb, 2, "sub");
    // Offer a bogus beat while Z is pending; it must not be taken.
    bus_valid = 1'b1;
    bus_data  = 8'd99;
    bus_op    = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (z_valid !== 1'b1 || z_out !== 8'd15 || {z_zero, z_neg, z_divzero, z_illegal} !== 4'b0000 ||
          bus_ready !== 1'b0 || alu_a !== 8'd20 || op_count !== 16'(exp_count)) begin
        errors++;
        $display("FAIL sub_hold[%0d]: zv=%0b z=%0d flags=%b rdy=%0b a=%0d cnt=%0d required 1/15/0000/0/20/%0d",
                 i, z_valid, z_out, {z_zero, z_neg, z_divzero, z_illegal}, bus_ready, alu_a,
                 op_count, exp_count);
      end
    end
    bus_valid = 1'b0;
    release_z("sub");
  endtask

  task automatic test_div();
    int ka, kb;
    beat(8'd20, 4'd7, ka);
    beat(8'd0, 4'd0, kb);
    sb.push_back('{z: 8'hFF, zero: 1'b0, neg: 1'b1, dz: 1'b1, ill: 1'b0});
    collect(kb, 2, "div0");
    release_z("div0");
    beat(8'd20, 4'd7, ka);
    beat(8'd5, 4'd0, kb);
    sb.push_back('{z: 8'd4, zero: 1'b0, neg: 1'b0, dz: 1'b0, ill: 1'b0});
    collect(kb, 2, "div");
    release_z("div");
  endtask

  task automatic test_illegal();
    int ka;
    logic [3:0] ops [2];
    ops[0] = 4'd13;
    ops[1] = 4'd6;
    for (int i = 0; i < 2; i++) begin
      beat(8'd9, ops[i], ka);
      sb.push_back('{z: 8'd0, zero: 1'b1, neg: 1'b0, dz: 1'b0, ill: 1'b1});
      checks++;
      if (bus_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_single_beat: op=%0d bus_ready=%0b required 0", ops[i], bus_ready);
      end
      collect(ka, 2, "illegal");
      release_z("illegal");
    end
  endtask

  task automatic test_clear_wait_b();
    int ka, kb;
    beat(8'd178, 4'd8, ka);
    @(negedge clock);
    clear     = 1'b1;
    bus_valid = 1'b1;
    bus_data  = 8'd99;
    @(posedge clock);
    #1;
    clear     = 1'b0;
    bus_valid = 1'b0;
    exp_count = 0;
    checks++;
    if ({bus_ready, busy, z_valid, z_zero, z_neg, z_divzero, z_illegal} !== 7'b1000000 ||
        alu_a !== 8'd0 || alu_b !== 8'd0 || alu_op !== 4'd0 || z_out !== 8'd0 ||
        op_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_wait_b: rdy/busy/zv/flags=%b a=%0d b=%0d op=%0d z=%0d cnt=%0d required 1000000 and zeros",
               {bus_ready, busy, z_valid, z_zero, z_neg, z_divzero, z_illegal},
               alu_a, alu_b, alu_op, z_out, op_count);
    end
    beat(8'd178, 4'd11, ka);
    beat(8'd2, 4'd0, kb);
    sb.push_back('{z: 8'b11001010, zero: 1'b0, neg: 1'b1, dz: 1'b0, ill: 1'b0});
    collect(kb, 2, "rol");
    release_z("rol");
  endtask

  initial begin
    test_reset();
    test_add();
    test_not_unary();
    test_backpressure();
    test_div();
    test_illegal();
    test_clear_wait_b();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
